// File: rtl/led_fader.sv
// Three-channel PWM LED driver that fades each channel's duty one step per
// fade tick towards a target colour accepted over a valid/ready handshake.
module led_fader #(
    parameter int fade_bit = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    input  logic [7:0] tgt_r,
    input  logic [7:0] tgt_g,
    input  logic [7:0] tgt_b,
    output logic       tgt_ready,
    output logic       busy,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [0:0] dbg_state_o,
    output logic [7:0] dbg_cur_r_o,
    output logic [7:0] dbg_cur_g_o,
    output logic [7:0] dbg_cur_b_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FADE = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [7:0]          pwm_cnt_q;
    logic [fade_bit-1:0] presc_q;
    logic                fade_tick;
    logic                xfer;

    logic [7:0] cur_r_q, cur_g_q, cur_b_q;
    logic [7:0] cur_r_d, cur_g_d, cur_b_d;
    logic [7:0] trg_r_q, trg_g_q, trg_b_q;
    logic [7:0] trg_r_d, trg_g_d, trg_b_d;
    logic [7:0] sh_r_q, sh_g_q, sh_b_q;
    logic       led_r_q, led_g_q, led_b_q;
    logic       tgt_ready_q, busy_q;

    // Moves one count towards the target; saturates by construction, never wraps.
    function automatic logic [7:0] step_towards(input logic [7:0] cur, input logic [7:0] trg);
        if (cur < trg)
            return cur + 8'd1;
        else if (cur > trg)
            return cur - 8'd1;
        else
            return cur;
    endfunction

    assign fade_tick = &presc_q;

    // Handshake: a target transfers on a rising edge where tgt_valid && tgt_ready;
    // tgt_ready is registered and only high in IDLE, so valid while not ready is dropped.
    assign xfer = tgt_valid && tgt_ready_q;

    always_comb begin
        state_d = state_q;
        cur_r_d = cur_r_q;
        cur_g_d = cur_g_q;
        cur_b_d = cur_b_q;
        trg_r_d = trg_r_q;
        trg_g_d = trg_g_q;
        trg_b_d = trg_b_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    trg_r_d = tgt_r;
                    trg_g_d = tgt_g;
                    trg_b_d = tgt_b;
                    if ((tgt_r != cur_r_q) || (tgt_g != cur_g_q) || (tgt_b != cur_b_q))
                        state_d = FADE;
                end
            end
            FADE: begin
                if (fade_tick) begin
                    cur_r_d = step_towards(cur_r_q, trg_r_q);
                    cur_g_d = step_towards(cur_g_q, trg_g_q);
                    cur_b_d = step_towards(cur_b_q, trg_b_q);
                    if ((cur_r_d == trg_r_q) && (cur_g_d == trg_g_q) && (cur_b_d == trg_b_q))
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pwm_cnt_q   <= 8'd0;
            presc_q     <= '0;
            cur_r_q     <= 8'd0;
            cur_g_q     <= 8'd0;
            cur_b_q     <= 8'd0;
            trg_r_q     <= 8'd0;
            trg_g_q     <= 8'd0;
            trg_b_q     <= 8'd0;
            sh_r_q      <= 8'd0;
            sh_g_q      <= 8'd0;
            sh_b_q      <= 8'd0;
            led_r_q     <= 1'b0;
            led_g_q     <= 1'b0;
            led_b_q     <= 1'b0;
            tgt_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwm_cnt_q   <= pwm_cnt_q + 8'd1;
            presc_q     <= presc_q + fade_bit'(1);
            cur_r_q     <= cur_r_d;
            cur_g_q     <= cur_g_d;
            cur_b_q     <= cur_b_d;
            trg_r_q     <= trg_r_d;
            trg_g_q     <= trg_g_d;
            trg_b_q     <= trg_b_d;
            // Shadow duty only moves at the period boundary so a PWM period is never torn.
            if (pwm_cnt_q == 8'hFF) begin
                sh_r_q <= cur_r_q;
                sh_g_q <= cur_g_q;
                sh_b_q <= cur_b_q;
            end
            led_r_q     <= pwm_cnt_q < sh_r_q;
            led_g_q     <= pwm_cnt_q < sh_g_q;
            led_b_q     <= pwm_cnt_q < sh_b_q;
            tgt_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d == FADE);
        end
    end

    assign tgt_ready   = tgt_ready_q;
    assign busy        = busy_q;
    assign led_r       = led_r_q;
    assign led_g       = led_g_q;
    assign led_b       = led_b_q;
    assign dbg_state_o = state_q;
    assign dbg_cur_r_o = cur_r_q;
    assign dbg_cur_g_o = cur_g_q;
    assign dbg_cur_b_o = cur_b_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader (fade_bit = 4): expectations are queued by the
// driver and compared by a monitor just after the following rising edge.
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgt_valid = 1'b0;
  logic [7:0] tgt_r = 8'd0;
  logic [7:0] tgt_g = 8'd0;
  logic [7:0] tgt_b = 8'd0;
  logic       tgt_ready, busy, led_r, led_g, led_b;
  logic [0:0] dbg_state;
  logic [7:0] dbg_cur_r, dbg_cur_g, dbg_cur_b;

  always #5 clk = ~clk;

  led_fader #(.fade_bit(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .tgt_valid   (tgt_valid),
    .tgt_r       (tgt_r),
    .tgt_g       (tgt_g),
    .tgt_b       (tgt_b),
    .tgt_ready   (tgt_ready),
    .busy        (busy),
    .led_r       (led_r),
    .led_g       (led_g),
    .led_b       (led_b),
    .dbg_state_o (dbg_state),
    .dbg_cur_r_o (dbg_cur_r),
    .dbg_cur_g_o (dbg_cur_g),
    .dbg_cur_b_o (dbg_cur_b)
  );

  localparam int K_READY = 0, K_BUSY = 1, K_LR = 2, K_LG = 3, K_LB = 4;
  localparam int K_CR = 5, K_CG = 6, K_CB = 7, K_ST = 8;
  localparam int K_HR = 9, K_HG = 10, K_HB = 11;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  int ecnt = 0;   // model of the prescaler: value it holds after each edge
  int hi_r, hi_g, hi_b;

  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  function automatic string kname(input int k);
    case (k)
      K_READY: return "tgt_ready";
      K_BUSY:  return "busy";
      K_LR:    return "led_r";
      K_LG:    return "led_g";
      K_LB:    return "led_b";
      K_CR:    return "cur_r";
      K_CG:    return "cur_g";
      K_CB:    return "cur_b";
      K_ST:    return "state";
      K_HR:    return "led_r_high_per_period";
      K_HG:    return "led_g_high_per_period";
      K_HB:    return "led_b_high_per_period";
      default: return "unknown";
    endcase
  endfunction

  function automatic int observe(input int k);
    case (k)
      K_READY: return int'(tgt_ready);
      K_BUSY:  return int'(busy);
      K_LR:    return int'(led_r);
      K_LG:    return int'(led_g);
      K_LB:    return int'(led_b);
      K_CR:    return int'(dbg_cur_r);
      K_CG:    return int'(dbg_cur_g);
      K_CB:    return int'(dbg_cur_b);
      K_ST:    return int'(dbg_state);
      K_HR:    return hi_r;
      K_HG:    return hi_g;
      K_HB:    return hi_b;
      default: return -1;
    endcase
  endfunction

  // monitor: drain every expectation queued before this edge
  logic [23:0] mon_e;
  int mon_k, mon_v, mon_a;
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_k = int'(mon_e[23:16]);
      mon_v = int'(mon_e[15:0]);
      mon_a = observe(mon_k);
      checks++;
      if (mon_a != mon_v) begin
        errors++;
        $display("FAIL %s at %0t: got %0d expected %0d", kname(mon_k), $time, mon_a, mon_v);
      end
    end
  end

  task automatic expect_v(input int k, input int v);
    exp_q.push_back({k[7:0], v[15:0]});
  endtask

  task automatic expect_cur(input int r, input int g, input int b);
    expect_v(K_CR, r);
    expect_v(K_CG, g);
    expect_v(K_CB, b);
  endtask

  task automatic expect_leds0();
    expect_v(K_LR, 0);
    expect_v(K_LG, 0);
    expect_v(K_LB, 0);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one target for a single cycle; the expected handshake result is
  // queued for the edge that performs the transfer.
  task automatic send_exp(input int r, input int g, input int b, input int exp_busy);
    tgt_valid = 1'b1;
    tgt_r = r[7:0];
    tgt_g = g[7:0];
    tgt_b = b[7:0];
    expect_v(K_BUSY, exp_busy);
    expect_v(K_READY, 1 - exp_busy);
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy got 1 after %0d cycles expected 0", n);
    end
  endtask

  // Leaves the driver at the negedge just after the n-th fade-tick edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      while (ecnt % 16 != 15) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic measure(input int er, input int eg, input int eb);
    hi_r = 0;
    hi_g = 0;
    hi_b = 0;
    repeat (256) begin
      @(posedge clk);
      #2;
      hi_r += int'(led_r);
      hi_g += int'(led_g);
      hi_b += int'(led_b);
    end
    @(negedge clk);
    expect_v(K_HR, er);
    expect_v(K_HG, eg);
    expect_v(K_HB, eb);
  endtask

  initial begin
    // reset held for three edges
    rst = 1'b1;
    @(negedge clk);
    expect_leds0();
    expect_v(K_BUSY, 0);
    expect_v(K_READY, 0);
    @(negedge clk);
    expect_v(K_READY, 0);
    expect_v(K_BUSY, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_v(K_READY, 1);
    expect_v(K_BUSY, 0);
    expect_v(K_ST, 0);
    expect_cur(0, 0, 0);
    @(negedge clk);

    // up-fade to (255,0,128): transfer on edge 1, final tick on edge 4079
    send_exp(255, 0, 128, 1);
    wait_neg(99);
    tgt_valid = 1'b1;
    tgt_r = 8'd10;
    tgt_g = 8'd10;
    tgt_b = 8'd10;
    wait_neg(1);
    tgt_valid = 1'b0;
    expect_v(K_BUSY, 1);
    expect_v(K_READY, 0);
    wait_neg(3976);
    expect_v(K_BUSY, 1);
    expect_cur(254, 0, 128);
    wait_neg(1);
    expect_v(K_BUSY, 0);
    expect_v(K_READY, 1);
    expect_v(K_ST, 0);
    expect_cur(255, 0, 128);
    wait_neg(1);

    // target equal to current: stays idle
    send_exp(255, 0, 128, 0);
    expect_v(K_BUSY, 0);
    expect_v(K_READY, 1);
    wait_neg(300);
    measure(255, 0, 128);

    // settle at 64 on every channel
    send_exp(64, 64, 64, 1);
    wait_idle(5000);
    expect_cur(64, 64, 64);
    wait_neg(300);
    measure(64, 64, 64);

    // climb to 200, then down-fade to 0
    send_exp(200, 200, 200, 1);
    wait_idle(5000);
    expect_cur(200, 200, 200);
    wait_neg(1);
    send_exp(0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      while (ecnt % 16 != 15) @(negedge clk);
      expect_cur(200 - i, 200 - i, 200 - i);
      @(negedge clk);
      expect_cur(200 - i, 200 - i, 200 - i);
    end
    wait_idle(5000);
    expect_cur(0, 0, 0);
    expect_v(K_ST, 0);
    wait_neg(300);
    expect_leds0();
    measure(0, 0, 0);
    wait_neg(40);
    expect_cur(0, 0, 0);
    wait_neg(1);

    // reset pulse in the middle of a fade
    send_exp(255, 255, 255, 1);
    wait_ticks(100);
    expect_v(K_CR, 100);
    expect_v(K_BUSY, 1);
    @(negedge clk);
    rst = 1'b1;
    expect_leds0();
    expect_cur(0, 0, 0);
    expect_v(K_BUSY, 0);
    expect_v(K_READY, 0);
    expect_v(K_ST, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_v(K_READY, 1);
    expect_v(K_BUSY, 0);
    expect_leds0();
    expect_cur(0, 0, 0);
    wait_neg(20);
    expect_v(K_BUSY, 0);
    expect_cur(0, 0, 0);
    wait_neg(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 SHALL have parameter fade_bit, default 16: width of the fade-tick prescaler, giving one fade step every 2^fade_bit clocks.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port tgt_valid, input, 1 bit: the target colour on tgt_r/tgt_g/tgt_b is valid.
REQ-005 SHALL have ports tgt_r, tgt_g, tgt_b, input, 8 bits each: target duty per channel (0..255).
REQ-006 SHALL have port tgt_ready, output, 1 bit, registered: the block accepts a new target.
REQ-007 SHALL have port busy, output, 1 bit, registered: a fade is in progress.
REQ-008 SHALL have ports led_r, led_g, led_b, output, 1 bit each, registered: PWM drive per channel, active-high.

Function
REQ-009 SHALL keep an 8-bit free-running PWM counter pwm_cnt that increments every clock and wraps 255->0.
REQ-010 SHALL keep an 8-bit current duty cur_x and an 8-bit shadow duty sh_x per channel.
REQ-011 SHALL load sh_x <= cur_x only on the clock where pwm_cnt == 255, so duty changes take effect only at a period boundary (glitch-free).
REQ-012 SHALL register led_x <= (pwm_cnt < sh_x) every clock: duty 0 gives constant low, duty 255 gives high for 255 of every 256 clocks.
REQ-013 SHALL keep a fade_bit-wide free-running prescaler; fade_tick SHALL be asserted for one clock when the prescaler is all-ones, then the prescaler wraps.
REQ-014 SHALL implement a state machine with states IDLE and FADE.
REQ-015 In IDLE, tgt_ready SHALL be 1 and busy SHALL be 0.
REQ-016 In FADE, tgt_ready SHALL be 0 and busy SHALL be 1.
REQ-017 A transfer SHALL occur when tgt_valid && tgt_ready at a clock edge; on transfer, tgt_x SHALL be latched into internal registers.
REQ-018 On a transfer whose target differs from cur_x on any channel, the state SHALL go to FADE: tgt_ready SHALL fall and busy SHALL rise on the next clock.
REQ-019 On a transfer equal to cur_x on all channels, the state SHALL stay IDLE and tgt_ready SHALL stay 1.
REQ-020 tgt_valid while not ready SHALL be ignored; the latched target SHALL be unchanged.
REQ-021 In FADE, on each fade_tick every channel SHALL step independently: cur_x +1 if below target, -1 if above, unchanged if equal. Stepping SHALL never overshoot or wrap (no 255->0, no 0->255).
REQ-022 On the fade_tick clock where the last channel reaches its target, the state SHALL return to IDLE: busy 0 and tgt_ready 1 on the following clock.
REQ-023 The prescaler and pwm_cnt SHALL free-run regardless of state; a fade's first step occurs on the first fade_tick after the transfer, not aligned to the transfer.

Reset
REQ-024 While rst == 1 at a clock edge, the following SHALL be forced on that edge: pwm_cnt, prescaler, cur_x, sh_x and latched targets to 0; state to IDLE; led_r/led_g/led_b, busy and tgt_ready to 0.
REQ-025 tgt_ready SHALL become 1 on the first clock edge with rst == 0.
REQ-026 Reset mid-fade SHALL abandon the fade; no state SHALL survive reset.

Verification
REQ-027 The bench SHALL cover reset: rst high 3 cycles -> led_* = 0, busy = 0, tgt_ready = 0 during reset; tgt_ready = 1 one edge after release.
REQ-028 The bench SHALL cover a fade with fade_bit = 4: target (255,0,128) accepted from reset -> busy = 1 next clock; cur_r reaches 255 after 255 ticks (~4080 clocks); cur_b stops at 128; busy = 0 and tgt_ready = 1 the clock after the final tick.
REQ-029 The bench SHALL cover steady PWM: settled duty 64 on R -> led_r high exactly 64 clocks of each 256-clock period; duty 0 -> never high; duty 255 -> low exactly 1 clock per period.
REQ-030 The bench SHALL cover the handshake: tgt_valid pulsed with (10,10,10) during a fade -> ignored, fade ends at the original target. After the fade, a target equal to current -> busy stays 0.
REQ-031 The bench SHALL cover a down-fade: from (200,200,200), target (0,0,0) -> each cur_x decrements once per tick, stops at 0 without wrap, led_* constant low after the next period boundary.
REQ-032 The bench SHALL cover reset mid-fade: rst pulsed for 1 clock at cur_r = 100 -> all led_* = 0, cur_* = 0, IDLE, tgt_ready = 1 one edge after release.
